clkdiv_prog: RTL and testbench

- Runtime-programmable successor to the fixed 32 kHz counter divider; parametrised counter width and reset-default divide value.
- Produces a 50%-duty divided clock plus single-cycle rise/fall strobes in the `clk` domain.
- Supports enable/hold and glitch-free divide-value reload at half-period boundaries.
- Sits beside the 100 MHz system clock and feeds slow timebases such as scan, debounce and audio-tick logic.

---
 rtl/clkdiv_pkg.sv | 12 +
 rtl/clkdiv_reload_ctrl.sv | 71 +++++++
 rtl/clkdiv_prog.sv | 83 ++++++++
 tb/tb_clkdiv_prog.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/clkdiv_pkg.sv
// Shared constants and helpers for the programmable clock divider.
package clkdiv_pkg;

    localparam int unsigned CLK_SYS_HZ    = 100_000_000;
    localparam int          CNT_WIDTH_DEF = 32;

    // Half-period terminal count that yields output frequency f from the system clock.
    function automatic int unsigned div_for_hz(input int unsigned f);
        return CLK_SYS_HZ / (2 * f) - 1;
    endfunction

endpackage

// File: rtl/clkdiv_reload_ctrl.sv
// Divide-value reload control: shadow register, pending flag and active-value mux.
// The active value only changes on a half-period boundary (tc) while running, or
// immediately while frozen, so the divided output never sees a shortened half-period.
module clkdiv_reload_ctrl
    import clkdiv_pkg::*;
#(
    parameter int          CNT_WIDTH   = CNT_WIDTH_DEF,
    parameter int unsigned DEFAULT_DIV = 1561
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    input  logic                 load,
    input  logic                 tc,
    input  logic [CNT_WIDTH-1:0] div_value,
    output logic [CNT_WIDTH-1:0] div_active,
    output logic                 reload_pending,
    output logic                 clear_cnt
);

    localparam logic [CNT_WIDTH-1:0] DEF_DIV = CNT_WIDTH'(DEFAULT_DIV);

    logic [CNT_WIDTH-1:0] shadow_q, shadow_d;
    logic [CNT_WIDTH-1:0] active_q, active_d;
    logic                 pend_q, pend_d;

    // Next-state selection for shadow, active value and pending flag.
    always_comb begin
        shadow_d = shadow_q;
        active_d = active_q;
        pend_d   = pend_q;
        if (!enable) begin
            // Frozen: a load takes effect at once and restarts the half-period.
            if (load) begin
                shadow_d = div_value;
                active_d = div_value;
                pend_d   = 1'b0;
            end
        end else if (tc) begin
            // Boundary: a same-cycle load wins over any older pending value.
            if (load) begin
                shadow_d = div_value;
                active_d = div_value;
            end else if (pend_q) begin
                active_d = shadow_q;
            end
            pend_d = 1'b0;
        end else if (load) begin
            shadow_d = div_value;
            pend_d   = 1'b1;
        end
    end

    // Register state with synchronous reset to the default divide.
    always_ff @(posedge clk) begin
        if (reset) begin
            shadow_q <= DEF_DIV;
            active_q <= DEF_DIV;
            pend_q   <= 1'b0;
        end else begin
            shadow_q <= shadow_d;
            active_q <= active_d;
            pend_q   <= pend_d;
        end
    end

    assign div_active     = active_q;
    assign reload_pending = pend_q;
    assign clear_cnt      = !enable && load;

endmodule

// File: rtl/clkdiv_prog.sv
// Runtime-programmable 50%-duty clock divider with rise/fall strobes.
// Half-period is div_active+1 clk cycles; output toggles only at terminal count.
module clkdiv_prog
    import clkdiv_pkg::*;
#(
    parameter int          CNT_WIDTH   = CNT_WIDTH_DEF,
    parameter int unsigned DEFAULT_DIV = div_for_hz(32_000)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    input  logic [CNT_WIDTH-1:0] div_value,
    input  logic                 load,
    output logic                 divided_clk,
    output logic                 tick_rise,
    output logic                 tick_fall,
    output logic                 reload_pending,
    output logic [CNT_WIDTH-1:0] div_active
);

    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic                 dclk_q, dclk_d;
    logic                 rise_q, rise_d;
    logic                 fall_q, fall_d;
    logic                 tc;
    logic                 clear_cnt;

    // >= rather than == so a stray counter value can never run past the boundary.
    assign tc = enable && (cnt_q >= div_active);

    clkdiv_reload_ctrl #(
        .CNT_WIDTH   (CNT_WIDTH),
        .DEFAULT_DIV (DEFAULT_DIV)
    ) u_reload (
        .clk            (clk),
        .reset          (reset),
        .enable         (enable),
        .load           (load),
        .tc             (tc),
        .div_value      (div_value),
        .div_active     (div_active),
        .reload_pending (reload_pending),
        .clear_cnt      (clear_cnt)
    );

    // Counter, output toggle and strobes all decided from the same tc.
    always_comb begin
        cnt_d  = cnt_q;
        dclk_d = dclk_q;
        rise_d = 1'b0;
        fall_d = 1'b0;
        if (clear_cnt) begin
            cnt_d = '0;
        end else if (tc) begin
            cnt_d  = '0;
            dclk_d = ~dclk_q;
            rise_d = ~dclk_q;
            fall_d = dclk_q;
        end else if (enable) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Register counter, divided clock and strobes; reset overrides everything.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q  <= '0;
            dclk_q <= 1'b0;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            dclk_q <= dclk_d;
            rise_q <= rise_d;
            fall_q <= fall_d;
        end
    end

    assign divided_clk = dclk_q;
    assign tick_rise   = rise_q;
    assign tick_fall   = fall_q;

endmodule

// File: tb/tb_clkdiv_prog.sv
// Directed bench for clkdiv_prog: expected strobe events are queued as stimulus
// is applied and matched by a monitor as the DUT emits them.
module tb_clkdiv_prog;

    typedef struct {
        int cyc;
        bit rise;
    } ev_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic [31:0] div_value;
    logic        load;
    logic        divided_clk;
    logic        tick_rise;
    logic        tick_fall;
    logic        reload_pending;
    logic [31:0] div_active;

    int  cyc    = 0;
    int  n_vec  = 0;
    int  n_err  = 0;
    ev_t exp_q[$];

    int R, B0, C0, D0, D1, D2, F0, RR;

    clkdiv_prog dut (
        .clk            (clk),
        .reset          (reset),
        .enable         (enable),
        .div_value      (div_value),
        .load           (load),
        .divided_clk    (divided_clk),
        .tick_rise      (tick_rise),
        .tick_fall      (tick_fall),
        .reload_pending (reload_pending),
        .div_active     (div_active)
    );

    always #5 clk = ~clk;

    // cyc equals the number of rising edges seen so far.
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d (cyc %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic push(input int c, input bit r);
        ev_t e;
        e.cyc  = c;
        e.rise = r;
        exp_q.push_back(e);
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    // All queued events should have been consumed by now.
    task automatic drain(input string tag);
        #1;
        chk(tag, exp_q.size(), 0);
    endtask

    // Monitor: every strobe must match the next queued event in cycle and kind.
    always @(negedge clk) begin
        ev_t e;
        if (tick_rise || tick_fall) begin
            if (exp_q.size() == 0) begin
                e.cyc  = -1;
                e.rise = 1'b0;
            end else begin
                e = exp_q.pop_front();
            end
            chk("tick_cyc", cyc, e.cyc);
            chk("tick_kind", {31'd0, tick_rise}, {31'd0, e.rise});
            chk("tick_excl", {31'd0, tick_rise & tick_fall}, 0);
        end
    end

    initial begin
        reset     = 1'b1;
        enable    = 1'b1;
        load      = 1'b0;
        div_value = 32'd0;

        // Reset state
        wait_until(4);
        chk("rst_dclk", {31'd0, divided_clk}, 0);
        chk("rst_rise", {31'd0, tick_rise}, 0);
        chk("rst_fall", {31'd0, tick_fall}, 0);
        chk("rst_pend", {31'd0, reload_pending}, 0);
        chk("rst_div", div_active, 1561);

        // Free-run with default divide
        reset = 1'b0;
        R = cyc;
        push(R + 1562, 1'b1);
        push(R + 3124, 1'b0);
        push(R + 4686, 1'b1);
        wait_until(R + 1561);
        chk("a_pre_rise", {31'd0, divided_clk}, 0);
        wait_until(R + 4686);
        chk("a_dclk", {31'd0, divided_clk}, 1);
        drain("a_drain");

        // Mid-period reload, last load wins (7 then 3)
        B0 = R + 4686;
        push(B0 + 1562, 1'b0);
        push(B0 + 1566, 1'b1);
        push(B0 + 1570, 1'b0);
        push(B0 + 1574, 1'b1);
        wait_until(B0 + 499);
        load = 1'b1; div_value = 32'd7;
        wait_until(B0 + 500);
        div_value = 32'd3;
        wait_until(B0 + 501);
        load = 1'b0;
        chk("b_pend_set", {31'd0, reload_pending}, 1);
        chk("b_div_hold", div_active, 1561);
        wait_until(B0 + 1561);
        chk("b_pend_tc-1", {31'd0, reload_pending}, 1);
        chk("b_dclk_tc-1", {31'd0, divided_clk}, 1);
        wait_until(B0 + 1562);
        chk("b_pend_clr", {31'd0, reload_pending}, 0);
        chk("b_div_new", div_active, 3);
        wait_until(B0 + 1574);
        drain("b_drain");

        // Load 0 exactly in the terminal-count cycle
        C0 = B0 + 1574;
        push(C0 + 4, 1'b0);
        push(C0 + 5, 1'b1);
        push(C0 + 6, 1'b0);
        push(C0 + 7, 1'b1);
        wait_until(C0 + 3);
        load = 1'b1; div_value = 32'd0;
        wait_until(C0 + 4);
        load = 1'b0;
        chk("c_div0", div_active, 0);
        chk("c_pend", {31'd0, reload_pending}, 0);
        wait_until(C0 + 7);
        drain("c_drain");

        // Load while disabled: immediate, counter restarts, level kept
        D0 = C0 + 7;
        enable = 1'b0; load = 1'b1; div_value = 32'd9;
        wait_until(D0 + 1);
        load = 1'b0;
        chk("e_div9", div_active, 9);
        chk("e_pend", {31'd0, reload_pending}, 0);
        chk("e_dclk", {31'd0, divided_clk}, 1);
        wait_until(D0 + 4);
        chk("e_dclk_hold", {31'd0, divided_clk}, 1);
        enable = 1'b1;
        D1 = D0 + 4;
        push(D1 + 10, 1'b0);
        push(D1 + 20, 1'b1);
        wait_until(D1 + 9);
        chk("e_pre_tog", {31'd0, divided_clk}, 1);
        wait_until(D1 + 20);
        drain("e_drain");

        // Hold at counter=5 for 50 cycles with a reload pending across the hold
        D2 = D1 + 20;
        push(D2 + 60, 1'b0);
        push(D2 + 63, 1'b1);
        wait_until(D2 + 4);
        load = 1'b1; div_value = 32'd2;
        wait_until(D2 + 5);
        load = 1'b0; enable = 1'b0;
        chk("d_pend", {31'd0, reload_pending}, 1);
        wait_until(D2 + 30);
        chk("d_hold_dclk", {31'd0, divided_clk}, 1);
        chk("d_hold_pend", {31'd0, reload_pending}, 1);
        chk("d_hold_div", div_active, 9);
        wait_until(D2 + 55);
        enable = 1'b1;
        wait_until(D2 + 59);
        chk("d_div_pre", div_active, 9);
        chk("d_dclk_pre", {31'd0, divided_clk}, 1);
        wait_until(D2 + 60);
        chk("d_div_post", div_active, 2);
        chk("d_pend_post", {31'd0, reload_pending}, 0);
        wait_until(D2 + 63);
        drain("d_drain");

        // Reset mid-period with load asserted
        F0 = D2 + 63;
        enable = 1'b0; load = 1'b1; div_value = 32'd1561;
        wait_until(F0 + 1);
        load = 1'b0; enable = 1'b1;
        chk("f_div", div_active, 1561);
        wait_until(F0 + 1001);
        chk("f_dclk_pre", {31'd0, divided_clk}, 1);
        reset = 1'b1; load = 1'b1; div_value = 32'd5;
        wait_until(F0 + 1002);
        chk("f_rst_dclk", {31'd0, divided_clk}, 0);
        chk("f_rst_rise", {31'd0, tick_rise}, 0);
        chk("f_rst_fall", {31'd0, tick_fall}, 0);
        chk("f_rst_pend", {31'd0, reload_pending}, 0);
        chk("f_rst_div", div_active, 1561);
        reset = 1'b0; load = 1'b0;
        RR = F0 + 1002;
        push(RR + 1562, 1'b1);
        wait_until(RR + 1561);
        chk("f_pre_rise", {31'd0, divided_clk}, 0);
        wait_until(RR + 1562);
        chk("f_rise", {31'd0, divided_clk}, 1);
        drain("f_drain");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
